// File: rtl/collision_checker.sv
// collision_checker
//   Sequential collision test for a 4x4 piece on a BOARD_W x BOARD_H board.
//   A request captures the board, anchor position and piece mask. The checker
//   then walks the 16 mask bits, one per clock. For every occupied piece cell
//   it clears the fits / move-left / move-right / move-down accumulators
//   whenever the cell, or its neighbour in that direction, is blocked. A
//   one-cycle done pulse publishes the results, and they hold until the next
//   done.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   board           occupancy bits, cell (x,y) at bit x+BOARD_W*y, 1 = occupied
//   block_xpos      piece anchor column
//   block_ypos      piece anchor row
//   block_mask      4x4 shape, bit r*4+c is the cell at (xpos+c, ypos+r)
//   req             start a check (ignored while busy)
//   busy            check in progress
//   done            one-cycle pulse, results valid
//   can_move_down   piece could move one row down
//   can_move_left   piece could move one column left
//   can_move_right  piece could move one column right
//   fits            piece lies in bounds on empty cells
module collision_checker #(
    parameter int BOARD_W = 16,
    parameter int BOARD_H = 16,
    parameter int POS_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BOARD_W*BOARD_H-1:0] board,
    input  logic [POS_W-1:0]           block_xpos,
    input  logic [POS_W-1:0]           block_ypos,
    input  logic [15:0]                block_mask,
    input  logic                       req,
    output logic                       busy,
    output logic                       done,
    output logic                       can_move_down,
    output logic                       can_move_left,
    output logic                       can_move_right,
    output logic                       fits
);

    localparam int CELLS = BOARD_W * BOARD_H;
    // Two extra bits so that pos+3 (and a neighbour) never wraps.
    localparam int CW    = POS_W + 2;

    localparam logic [CW-1:0]    W_C  = CW'(BOARD_W);
    localparam logic [CW-1:0]    H_C  = CW'(BOARD_H);
    localparam logic [CW-1:0]    W_M1 = CW'(BOARD_W - 1);
    localparam logic [CW-1:0]    H_M1 = CW'(BOARD_H - 1);
    localparam logic [CW-1:0]    C_ONE = CW'(1);
    localparam logic [CELLS-1:0] B_ONE = CELLS'(1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state;
    logic [3:0]         scan_idx;

    logic [CELLS-1:0]   board_q;
    logic [POS_W-1:0]   xpos_q;
    logic [POS_W-1:0]   ypos_q;
    logic [15:0]        mask_q;

    logic               acc_fits;
    logic               acc_left;
    logic               acc_right;
    logic               acc_down;

    logic [CW-1:0]      cx;
    logic [CW-1:0]      cy;
    logic [CW-1:0]      cx_m1;
    logic [CW-1:0]      cx_p1;
    logic [CW-1:0]      cy_p1;
    logic               clr_fits;
    logic               clr_left;
    logic               clr_right;
    logic               clr_down;

    // Occupancy lookup. Callers guarantee (x,y) is on the board, so the
    // one-hot select never falls outside the vector.
    function automatic logic cell_at(input logic [CELLS-1:0] b,
                                     input logic [CW-1:0]    x,
                                     input logic [CW-1:0]    y);
        int unsigned idx;
        idx = 32'(x) + 32'(BOARD_W) * 32'(y);
        return |(b & (B_ONE << idx));
    endfunction

    // Evaluation of the mask bit selected by scan_idx (row = idx[3:2],
    // column = idx[1:0]). Each bounds test comes first and suppresses its
    // board lookup. Neighbours off the board count as empty.
    always_comb begin
        cx        = CW'(xpos_q) + CW'(scan_idx[1:0]);
        cy        = CW'(ypos_q) + CW'(scan_idx[3:2]);
        cx_m1     = cx - C_ONE;
        cx_p1     = cx + C_ONE;
        cy_p1     = cy + C_ONE;
        clr_fits  = 1'b0;
        clr_left  = 1'b0;
        clr_right = 1'b0;
        clr_down  = 1'b0;

        if (cx >= W_C || cy >= H_C)
            clr_fits = 1'b1;
        else
            clr_fits = cell_at(board_q, cx, cy);

        if (cx == '0)
            clr_left = 1'b1;
        else if (cy < H_C && cx_m1 < W_C)
            clr_left = cell_at(board_q, cx_m1, cy);

        if (cx >= W_M1)
            clr_right = 1'b1;
        else if (cy < H_C)
            clr_right = cell_at(board_q, cx_p1, cy);

        if (cy >= H_M1)
            clr_down = 1'b1;
        else if (cx < W_C)
            clr_down = cell_at(board_q, cx, cy_p1);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            scan_idx       <= 4'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            can_move_down  <= 1'b0;
            can_move_left  <= 1'b0;
            can_move_right <= 1'b0;
            fits           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state    <= SCAN;
                        scan_idx <= 4'd0;
                        busy     <= 1'b1;
                    end
                end
                SCAN: begin
                    scan_idx <= scan_idx + 4'd1;
                    if (scan_idx == 4'd15)
                        state <= DONE;
                end
                DONE: begin
                    can_move_down  <= acc_down;
                    can_move_left  <= acc_left;
                    can_move_right <= acc_right;
                    fits           <= acc_fits;
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Captured operands and accumulators. These are pure data and need no
    // reset, because a fresh capture always precedes any use.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            board_q   <= board;
            xpos_q    <= block_xpos;
            ypos_q    <= block_ypos;
            mask_q    <= block_mask;
            acc_fits  <= 1'b1;
            acc_left  <= 1'b1;
            acc_right <= 1'b1;
            acc_down  <= 1'b1;
        end else if (state == SCAN && mask_q[scan_idx]) begin
            acc_fits  <= acc_fits  & ~clr_fits;
            acc_left  <= acc_left  & ~clr_left;
            acc_right <= acc_right & ~clr_right;
            acc_down  <= acc_down  & ~clr_down;
        end
    end

endmodule

// File: tb/tb_collision_checker.sv
`timescale 1ns/1ps
module tb_collision_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT, 16x16 board
    logic         rst = 1'b0;
    logic [255:0] board = '0;
    logic [7:0]   xpos = 8'd0;
    logic [7:0]   ypos = 8'd0;
    logic [15:0]  mask = 16'd0;
    logic         req = 1'b0;
    logic         busy, done, cmd, cml, cmr, fits;

    // Second DUT, 10x20 board
    logic [199:0] board2 = '0;
    logic [7:0]   xpos2 = 8'd0;
    logic [7:0]   ypos2 = 8'd0;
    logic [15:0]  mask2 = 16'd0;
    logic         req2 = 1'b0;
    logic         busy2, done2, cmd2, cml2, cmr2, fits2;

    int checks   = 0;
    int failures = 0;

    collision_checker dut (
        .clk(clk), .rst(rst), .board(board), .block_xpos(xpos),
        .block_ypos(ypos), .block_mask(mask), .req(req), .busy(busy),
        .done(done), .can_move_down(cmd), .can_move_left(cml),
        .can_move_right(cmr), .fits(fits)
    );

    collision_checker #(.BOARD_W(10), .BOARD_H(20), .POS_W(8)) dut2 (
        .clk(clk), .rst(rst), .board(board2), .block_xpos(xpos2),
        .block_ypos(ypos2), .block_mask(mask2), .req(req2), .busy(busy2),
        .done(done2), .can_move_down(cmd2), .can_move_left(cml2),
        .can_move_right(cmr2), .fits(fits2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic occ(input logic [1023:0] b, input int w, input int h,
                                 input int x, input int y);
        logic [1023:0] t;
        if (x < 0 || y < 0 || x >= w || y >= h) return 1'b0;
        t = b >> (x + w * y);
        return t[0];
    endfunction

    function automatic void calc(input logic [1023:0] b, input int w, input int h,
                                 input int xp, input int yp, input logic [15:0] m,
                                 output logic f, output logic l,
                                 output logic rr, output logic d);
        logic [15:0] mm;
        int x, y;
        f = 1'b1; l = 1'b1; rr = 1'b1; d = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                mm = m >> (r * 4 + c);
                if (mm[0]) begin
                    x = xp + c;
                    y = yp + r;
                    if (x >= w || y >= h || occ(b, w, h, x, y)) f = 1'b0;
                    if (x == 0 || occ(b, w, h, x - 1, y))       l = 1'b0;
                    if (x >= w - 1 || occ(b, w, h, x + 1, y))   rr = 1'b0;
                    if (y >= h - 1 || occ(b, w, h, x, y + 1))   d = 1'b0;
                end
            end
        end
    endfunction

    // Model of the main DUT: a request seen while idle yields results 17
    // clock edges later; requests while busy are dropped.
    logic m_busy = 1'b0, m_done = 1'b0;
    logic m_f = 1'b0, m_l = 1'b0, m_r = 1'b0, m_d = 1'b0;
    logic p_f = 1'b0, p_l = 1'b0, p_r = 1'b0, p_d = 1'b0;
    logic tf, tl, tr, td;
    int   m_left = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
            m_f <= 1'b0; m_l <= 1'b0; m_r <= 1'b0; m_d <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_f <= p_f; m_l <= p_l; m_r <= p_r; m_d <= p_d;
                end
                m_left <= m_left - 1;
            end else if (req) begin
                calc({768'd0, board}, 16, 16, int'(xpos), int'(ypos), mask, tf, tl, tr, td);
                p_f <= tf; p_l <= tl; p_r <= tr; p_d <= td;
                m_busy <= 1'b1;
                m_left <= 17;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy",  busy, m_busy);
        chk("done",  done, m_done);
        chk("fits",  fits, m_f);
        chk("left",  cml,  m_l);
        chk("right", cmr,  m_r);
        chk("down",  cmd,  m_d);
    end

    // ---------------- directed stimulus ----------------
    task automatic run_check(input string name, input logic [255:0] b,
                             input int x, input int y, input logic [15:0] m,
                             input logic el, input logic er, input logic ed, input logic ef);
        int lat;
        logic f, l, rr, d;
        calc({768'd0, b}, 16, 16, x, y, m, f, l, rr, d);
        chk({name, "_model_l"}, l, el);
        chk({name, "_model_r"}, rr, er);
        chk({name, "_model_d"}, d, ed);
        chk({name, "_model_f"}, f, ef);
        @(posedge clk); #2;
        board = b; xpos = 8'(x); ypos = 8'(y); mask = m; req = 1'b1;
        @(posedge clk); #2;
        req = 1'b0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({name, "_latency"}, lat - 1, 17);
        #1;
        chk({name, "_left"},  cml,  el);
        chk({name, "_right"}, cmr,  er);
        chk({name, "_down"},  cmd,  ed);
        chk({name, "_fits"},  fits, ef);
    endtask

    task automatic run2(input string name, input int x, input int y, input logic [15:0] m,
                        input logic el, input logic er, input logic ed, input logic ef);
        int lat;
        logic f, l, rr, d;
        calc({824'd0, board2}, 10, 20, x, y, m, f, l, rr, d);
        chk({name, "_model_l"}, l, el);
        chk({name, "_model_f"}, f, ef);
        @(posedge clk); #2;
        xpos2 = 8'(x); ypos2 = 8'(y); mask2 = m; req2 = 1'b1;
        @(posedge clk); #2;
        req2 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done2 === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({name, "_latency"}, lat - 1, 17);
        #1;
        chk({name, "_left"},  cml2,  el);
        chk({name, "_right"}, cmr2,  er);
        chk({name, "_down"},  cmd2,  ed);
        chk({name, "_fits"},  fits2, ef);
    endtask

    initial begin
        logic [255:0] bb;
        int ndone;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fits", fits, 1'b0);
        chk("rst_left", cml,  1'b0);
        #1 rst = 1'b0;

        // 2x2 square in the top-left corner
        run_check("sq00", '0, 0, 0, 16'h0033, 1'b0, 1'b1, 1'b1, 1'b1);
        // Horizontal I on the bottom row
        run_check("i12", '0, 12, 15, 16'h000F, 1'b1, 1'b0, 1'b0, 1'b1);
        run_check("i13", '0, 13, 15, 16'h000F, 1'b1, 1'b0, 1'b0, 1'b0);
        // Single cell above and on an occupied cell
        bb = '0;
        bb[5 + 16 * 4] = 1'b1;
        run_check("dot_y3", bb, 5, 3, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1);
        run_check("dot_y4", bb, 5, 4, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b0);
        // T-like piece with an obstacle on its left
        bb = '0;
        bb[3 + 16 * 5] = 1'b1;
        run_check("tee", bb, 4, 4, 16'h0072, 1'b0, 1'b1, 1'b1, 1'b1);
        // Empty mask far off the board
        run_check("zmask", {256{1'b1}}, 250, 250, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);

        // Inputs toggled mid-scan, plus a second request while busy
        @(posedge clk); #2;
        board = '0; xpos = 8'd14; ypos = 8'd0; mask = 16'h0033; req = 1'b1;
        @(posedge clk); #2;
        req = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        board = {256{1'b1}}; xpos = 8'd0; req = 1'b1;
        @(posedge clk); #2;
        req = 1'b0;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("toggle_ndone", ndone, 1);
        chk("toggle_left",  cml,  1'b1);
        chk("toggle_right", cmr,  1'b0);
        chk("toggle_down",  cmd,  1'b1);
        chk("toggle_fits",  fits, 1'b1);

        // Reset at scan index 7
        @(posedge clk); #2;
        board = '0; xpos = 8'd0; ypos = 8'd0; mask = 16'h0001; req = 1'b1;
        @(posedge clk); #2;
        req = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy",  busy, 1'b0);
        chk("abort_done",  done, 1'b0);
        chk("abort_fits",  fits, 1'b0);
        chk("abort_left",  cml,  1'b0);
        chk("abort_right", cmr,  1'b0);
        chk("abort_down",  cmd,  1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort_ndone", ndone, 0);
        run_check("after_rst", '0, 12, 12, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);

        // 10x20 board
        run2("b10_corner", 9, 19, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
        run2("b10_out",   10, 19, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/collision_checker.md
COLLISION_CHECKER -- requirements
Module: collision_checker

Interface
REQ-001 SHALL provide parameter BOARD_W, default 16, board width in cells.
REQ-002 SHALL provide parameter BOARD_H, default 16, board height in cells.
REQ-003 SHALL provide parameter POS_W, default 8, width of piece position inputs.
REQ-004 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL provide port board  input  BOARD_W*BOARD_H  occupancy; cell (x,y) at bit x+BOARD_W*y; 1 = occupied.
REQ-007 SHALL provide port block_xpos  input  POS_W  piece anchor column (unsigned).
REQ-008 SHALL provide port block_ypos  input  POS_W  piece anchor row (unsigned).
REQ-009 SHALL provide port block_mask  input  16  4x4 piece shape; bit r*4+c set = cell at (xpos+c, ypos+r).
REQ-010 SHALL provide port req  input  1  start-check request.
REQ-011 SHALL provide port busy  output  1  check in progress.
REQ-012 SHALL provide port done  output  1  one-cycle pulse, results valid.
REQ-013 SHALL provide ports can_move_down, can_move_left, can_move_right  output  1 each  move legality.
REQ-014 SHALL provide port fits  output  1  piece at current position lies in-bounds on empty cells.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-016 In IDLE with req=1, SHALL capture board, block_xpos, block_ypos and block_mask into internal registers, clear scan index to 0, preset all four result accumulators to 1, and enter SCAN.
REQ-017 In SCAN, SHALL evaluate exactly one mask bit per cycle, index 0 to 15 ascending, using only captured values.
REQ-018 For a set mask bit: x = xpos+c, y = ypos+r, computed at POS_W+2 bits with no wrap.
REQ-019 If x>=BOARD_W or y>=BOARD_H or board[x+BOARD_W*y]=1, SHALL clear fits.
REQ-020 If x=0 or board[(x-1)+BOARD_W*y]=1, SHALL clear can_move_left.
REQ-021 If x>=BOARD_W-1 or board[(x+1)+BOARD_W*y]=1, SHALL clear can_move_right.
REQ-022 If y>=BOARD_H-1 or board[x+BOARD_W*(y+1)]=1, SHALL clear can_move_down.
REQ-023 SHALL never index board out of range; a bounds condition that clears a flag suppresses the corresponding board lookup.
REQ-024 Clear mask bits SHALL leave accumulators unchanged.
REQ-025 After index 15, SHALL enter DONE; in DONE, SHALL copy accumulators to outputs, assert done for exactly one cycle, and return to IDLE.
REQ-026 Latency: req sampled at edge N -> done high during cycle N+17; next req accepted at edge N+18.
REQ-027 busy SHALL be 1 in SCAN and DONE, and 0 in IDLE.
REQ-028 req while busy=1 SHALL be ignored (not queued).
REQ-029 Result outputs SHALL hold their values from the last DONE until the next DONE.
REQ-030 Input changes after capture SHALL NOT affect the check in progress.
REQ-031 An all-zero mask SHALL yield all four results = 1.
REQ-032 Flags are independent; the other three flags SHALL still be evaluated when fits=0.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, busy=0, done=0, can_move_down=0, can_move_left=0, can_move_right=0, fits=0, scan index 0.
REQ-034 rst asserted mid-SCAN or in DONE SHALL abort the check with no done pulse; the first req after rst deasserts SHALL start a fresh check.

Verification
REQ-035 Empty board, mask=0x0033 (2x2 square), xpos=0, ypos=0, req pulse -> done at +17 cycles, left=0, right=1, down=1, fits=1.
REQ-036 Empty board, mask=0x000F (horizontal I), xpos=12, ypos=15 -> left=1, right=0, down=0, fits=1; xpos=13 -> fits=0, right=0.
REQ-037 board bit 5+16*4 set, mask=0x0001, xpos=5, ypos=3 -> down=0, left=1, right=1, fits=1; repeat at ypos=4 -> fits=0.
REQ-038 Start check, toggle board/xpos/req during SCAN -> results match captured inputs only, one done pulse, second req ignored.
REQ-039 Assert rst at SCAN index 7 -> outputs all 0 immediately, no done; new req after release -> correct result 17 cycles later.
REQ-040 Parameters BOARD_W=10, BOARD_H=20, mask=0x0001, xpos=9, ypos=19 -> right=0, down=0, left=1, fits=1.
